// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite constants, FSM state type and the debug view exported by the top.
package ahb_lite_pkg;

  localparam int DATA_W     = 32;
  localparam int MEM_DEPTH  = 16;
  localparam int ADDR_W     = 4;
  localparam int NUM_SLAVES = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ADDR,
    ST_DATA,
    ST_WAIT_REL
  } state_t;

  // Snapshot of the master FSM and the bus it drives, for observation only.
  typedef struct packed {
    state_t      state;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hsel;
    logic        hresp;
  } dbg_t;

endpackage

// File: rtl/ahb_lite_slave_mem.sv
// Zero-wait-state AHB-Lite slave backed by a 16 x 32-bit register file.
// Address-phase controls are registered on a selected NONSEQ transfer and
// used during the following data phase.
module ahb_lite_slave_mem
  import ahb_lite_pkg::*;
(
  input  logic              hclk_i,
  input  logic              hreset_i,
  input  logic              hsel_i,
  input  logic [1:0]        htrans_i,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic              hwrite_i,
  input  logic [DATA_W-1:0] hwdata_i,
  output logic [DATA_W-1:0] hrdata_o,
  output logic              hreadyout_o,
  output logic              hresp_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic              dphase_q, dwrite_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              capture;

  assign capture = hsel_i && (htrans_i == HTRANS_NONSEQ);

  // Register address-phase controls so the data phase sees a stable target.
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      dphase_q <= 1'b0;
      dwrite_q <= 1'b0;
      daddr_q  <= '0;
    end else begin
      dphase_q <= capture;
      if (capture) begin
        dwrite_q <= hwrite_i;
        daddr_q  <= haddr_i;
      end
    end
  end

  // Commit write data at the end of the data phase; reset wins over a pending write.
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (dphase_q && dwrite_q) begin
      mem_q[daddr_q] <= hwdata_i;
    end
  end

  assign hrdata_o    = mem_q[daddr_q];
  assign hreadyout_o = 1'b1;
  assign hresp_o     = HRESP_OKAY;

endmodule

// File: rtl/ahb_lite_top.sv
// Single-transfer AHB-Lite master with HSEL decoder, four slaves and an
// HRDATA mux. One enable pulse produces exactly one transfer of dina+dinb
// (write) or one registered read into dout.
module ahb_lite_top
  import ahb_lite_pkg::*;
(
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              enable,
  input  logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] dinb,
  input  logic [31:0]       addr,
  input  logic              wr,
  input  logic [1:0]        slave_sel,
  output logic [DATA_W-1:0] dout,
  output dbg_t              dbg_o
);

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        dsel_q, dsel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic [1:0]              htrans;
  logic [NUM_SLAVES-1:0]   hsel;
  logic [DATA_W-1:0]       hwdata;
  logic [DATA_W-1:0]       hrdata;
  logic                    hready;
  logic                    hresp;
  logic [DATA_W-1:0]       hrdata_s [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]   hreadyout_s;
  logic [NUM_SLAVES-1:0]   hresp_s;
  logic                    unused_addr_hi;

  // Only the word index within a slave is meaningful.
  assign unused_addr_hi = ^addr[31:ADDR_W];

  // State and latched-operand registers.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      dsel_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      sum_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dsel_q  <= dsel_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      sum_q   <= sum_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and bus outputs. wr is taken in SETUP, not IDLE, since the user
  // may still be settling it on the cycle enable rises.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dsel_d  = dsel_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    sum_d   = sum_q;
    dout_d  = dout_q;
    htrans  = HTRANS_IDLE;
    hsel    = '0;
    hwdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          sel_d   = slave_sel;
          addr_d  = addr[ADDR_W-1:0];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wr_d    = wr;
        sum_d   = dina + dinb;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        htrans  = HTRANS_NONSEQ;
        hsel    = 4'b0001 << sel_q;
        dsel_d  = sel_q;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        hwdata = sum_q;
        if (hready) begin
          if (!wr_q) dout_d = hrdata;
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data-phase response mux keyed on the registered slave select.
  always_comb begin
    hrdata = hrdata_s[dsel_q];
    hready = hreadyout_s[dsel_q];
    hresp  = hresp_s[dsel_q];
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
    ahb_lite_slave_mem u_slave (
      .hclk_i      (hclk),
      .hreset_i    (hresetn),
      .hsel_i      (hsel[s]),
      .htrans_i    (htrans),
      .haddr_i     (addr_q),
      .hwrite_i    (wr_q),
      .hwdata_i    (hwdata),
      .hrdata_o    (hrdata_s[s]),
      .hreadyout_o (hreadyout_s[s]),
      .hresp_o     (hresp_s[s])
    );
  end

  assign dout = dout_q;

  always_comb begin
    dbg_o        = '0;
    dbg_o.state  = state_q;
    dbg_o.htrans = htrans;
    dbg_o.haddr  = {{(32-ADDR_W){1'b0}}, addr_q};
    dbg_o.hwrite = wr_q;
    dbg_o.hsize  = HSIZE_WORD;
    dbg_o.hsel   = hsel;
    dbg_o.hresp  = hresp;
  end

endmodule

// File: tb/tb_ahb_lite_top.sv
// Directed bench for ahb_lite_top: writes, read-back, slave isolation,
// carry wrap, reset mid-transfer and single transfer per enable.
module tb_ahb_lite_top;
  import ahb_lite_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        enable;
  logic [31:0] dina, dinb, addr;
  logic        wr;
  logic [1:0]  slave_sel;
  logic [31:0] dout;
  dbg_t        dbg;

  int          total = 0;
  int          bad = 0;
  int          nonseq_cnt = 0;
  logic [31:0] last_rd = '0;

  // Clock
  always #5 hclk = ~hclk;

  ahb_lite_top dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .enable    (enable),
    .dina      (dina),
    .dinb      (dinb),
    .addr      (addr),
    .wr        (wr),
    .slave_sel (slave_sel),
    .dout      (dout),
    .dbg_o     (dbg)
  );

  // Count address phases seen on the bus
  always @(negedge hclk) begin
    if (dbg.htrans == HTRANS_NONSEQ) nonseq_cnt <= nonseq_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction; inputs change on negedges. Operands and select are
  // scrambled after they should have been latched.
  task automatic txn(input logic [1:0] sel, input logic [3:0] a, input logic w,
                     input logic [31:0] opa, input logic [31:0] opb,
                     input int en_cycles, input logic stale, input logic [31:0] exp_dout);
    logic done;
    done = 1'b0;
    @(negedge hclk);
    enable    = 1'b1;
    slave_sel = sel;
    addr      = {28'($urandom()), a};
    wr        = stale ? ~w : w;
    dina      = opa;
    dinb      = opb;
    for (int i = 1; i <= 30; i++) begin
      @(negedge hclk);
      if (i == 1) begin
        wr        = w;
        slave_sel = ~sel;
        addr      = '0;
      end
      if (i == 2) begin
        dina = $urandom();
        dinb = $urandom();
      end
      if (i == en_cycles) enable = 1'b0;
      if (i == 4) chk(w ? "dout_hold" : "rd_data", dout, exp_dout);
      if (i >= en_cycles && dbg.state == ST_IDLE) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("txn_timeout", 32'(dbg.state), 32'(ST_IDLE));
  endtask

  task automatic wr_word(input logic [1:0] sel, input logic [3:0] a,
                         input logic [31:0] opa, input logic [31:0] opb);
    txn(sel, a, 1'b1, opa, opb, 2, 1'b0, last_rd);
  endtask

  task automatic rd_word(input logic [1:0] sel, input logic [3:0] a, input logic [31:0] exp);
    txn(sel, a, 1'b0, 32'h0, 32'h0, 5, 1'b1, exp);
    last_rd = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    hresetn = 1'b1; enable = 1'b0; wr = 1'b0;
    dina = '0; dinb = '0; addr = '0; slave_sel = '0;
    repeat (3) @(negedge hclk);
    chk("rst_dout",   dout, 32'h0);
    chk("rst_state",  32'(dbg.state), 32'(ST_IDLE));
    chk("rst_htrans", 32'(dbg.htrans), 32'(HTRANS_IDLE));
    chk("rst_hresp",  32'(dbg.hresp), 32'(HRESP_OKAY));
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);

    // Basic write then read with stale wr on the first cycle
    wr_word(2'd0, 4'd1, 32'd1, 32'd2);
    rd_word(2'd0, 4'd1, 32'd3);

    // Several slaves / addresses
    wr_word(2'd1, 4'd2, 32'd3, 32'd4);
    wr_word(2'd2, 4'd3, 32'd5, 32'd6);
    wr_word(2'd3, 4'd4, 32'd7, 32'd8);
    wr_word(2'd3, 4'd5, 32'd9, 32'd10);
    rd_word(2'd1, 4'd2, 32'd7);
    rd_word(2'd2, 4'd3, 32'd11);
    rd_word(2'd3, 4'd4, 32'd15);
    rd_word(2'd3, 4'd5, 32'd19);

    // Isolation between slaves
    rd_word(2'd0, 4'd2, 32'd0);
    rd_word(2'd3, 4'd4, 32'd15);

    // Carry is dropped; overwrite nonzero words so a zero result is meaningful
    wr_word(2'd2, 4'd9, 32'h55, 32'h0);
    rd_word(2'd2, 4'd9, 32'h55);
    wr_word(2'd2, 4'd9, 32'hFFFF_FFFF, 32'h1);
    rd_word(2'd2, 4'd9, 32'h0);
    wr_word(2'd1, 4'd10, 32'h1, 32'h1);
    rd_word(2'd1, 4'd10, 32'h2);
    wr_word(2'd1, 4'd10, 32'h8000_0000, 32'h8000_0000);
    rd_word(2'd1, 4'd10, 32'h0);

    // Long enable still gives one transfer
    n0 = nonseq_cnt;
    txn(2'd0, 4'd6, 1'b1, 32'h1234, 32'h1, 10, 1'b0, last_rd);
    chk("nonseq_once", 32'(nonseq_cnt - n0), 32'd1);
    rd_word(2'd0, 4'd6, 32'h1235);

    // Reset during the write data phase
    rd_word(2'd3, 4'd4, 32'd15);
    @(negedge hclk);
    enable = 1'b1; wr = 1'b1; slave_sel = 2'd1; addr = 32'd7;
    dina = 32'd100; dinb = 32'd23;
    repeat (3) @(negedge hclk);
    chk("pre_rst_state", 32'(dbg.state), 32'(ST_DATA));
    hresetn = 1'b1;
    @(negedge hclk);
    chk("midrst_dout",  dout, 32'h0);
    chk("midrst_state", 32'(dbg.state), 32'(ST_IDLE));
    enable = 1'b0; hresetn = 1'b0;
    @(negedge hclk);
    last_rd = '0;
    rd_word(2'd1, 4'd7, 32'h0);
    rd_word(2'd3, 4'd4, 32'h0);
    rd_word(2'd1, 4'd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
